// File: rtl/ir_fetch_queue_if.sv
// Fetch-queue bus: the fetch/control side (master) drives push, pop and flush;
// the queue (slave) returns the instruction register and occupancy status.
interface ir_fetch_queue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [WIDTH-1:0] rIR;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  full, empty, count, overflow, rIR
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output full, empty, count, overflow, rIR
    );
endinterface

// File: rtl/ir_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO feeding a registered IR that holds until popped.
// Optional macro IRQ_BYPASS_EN: a push+pop into an empty queue loads the IR directly.
module ir_fetch_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    ir_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_ir;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;
    logic w_drop;
    logic w_bypass;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_pop_ok = bus.rd_en & ~w_empty;

`ifdef IRQ_BYPASS_EN
    assign w_bypass = w_empty & bus.wr_en & bus.rd_en;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full queue still accepts a push.
    assign w_push_ok = bus.wr_en & (~w_full | w_pop_ok) & ~w_bypass;
    assign w_drop    = bus.wr_en & w_full & ~w_pop_ok;

    // Storage carries no reset; reset and flush only block the write.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ir       <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            // The IR deliberately keeps its value across a flush.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_bypass) begin
            r_ir <= bus.wr_data;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_ir     <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.rIR      = r_ir;
endmodule

// File: tb/tb_ir_fetch_queue.sv
// Bench for ir_fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ir_fetch_queue;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef IRQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   chk_en;

    ir_fetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ir_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of words plus the IR and sticky flag.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_ir;
    bit               m_ov;

    always @(posedge clk) begin
        bit pop;
        bit push;
        if (!rst_n) begin
            mq.delete();
            m_ir = '0;
            m_ov = 1'b0;
        end else if (bus.flush) begin
            mq.delete();
            m_ov = 1'b0;
        end else if (BYP && mq.size() == 0 && bus.wr_en && bus.rd_en) begin
            m_ir = bus.wr_data;
        end else begin
            pop  = bus.rd_en && (mq.size() > 0);
            push = bus.wr_en && ((mq.size() < DEPTH) || pop);
            if (bus.wr_en && !push) m_ov = 1'b1;
            if (pop) m_ir = mq.pop_front();
            if (push) mq.push_back(bus.wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (bus.rIR !== m_ir || int'(bus.count) != mq.size() ||
                bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == DEPTH) ||
                bus.overflow !== m_ov) begin
                bad++;
                $display("FAIL model t=%0t: rIR=%h cnt=%0d e=%b f=%b ov=%b required rIR=%h cnt=%0d e=%b f=%b ov=%b",
                         $time, bus.rIR, bus.count, bus.empty, bus.full, bus.overflow,
                         m_ir, mq.size(), (mq.size() == 0), (mq.size() == DEPTH), m_ov);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_rIR"}, int'(bus.rIR), 0);
        check({name, "_count"}, int'(bus.count), 0);
        check({name, "_empty"}, int'(bus.empty), 1);
        check({name, "_full"}, int'(bus.full), 0);
        check({name, "_ovf"}, int'(bus.overflow), 0);
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge with inputs idle.
    task automatic cyc(input bit rn, input bit fl, input bit wr, input logic [WIDTH-1:0] d, input bit rd);
        rst_n       = rn;
        bus.flush   = fl;
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        cyc(1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [WIDTH-1:0] fill [4];
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        fill   = '{8'h10, 8'h20, 8'h30, 8'h40};
        rst_n = 1'b1; bus.flush = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
        #2;

        // 1: reset
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk_en = 1'b1;
        check_reset("reset");

        // 2: fill and drain
        for (int i = 0; i < 4; i++) push(fill[i]);
        check("fill_full", int'(bus.full), 1);
        check("fill_count", int'(bus.count), 4);
        for (int i = 0; i < 4; i++) begin
            pop();
            check("drain_rIR", int'(bus.rIR), int'(fill[i]));
        end
        check("drain_empty", int'(bus.empty), 1);
        pop();
        check("extra_pop_rIR", int'(bus.rIR), 8'h40);

        // 3: overflow, then push with pop while full
        for (int i = 0; i < 4; i++) push(fill[i]);
        push(8'h50);
        check("ovf_flag", int'(bus.overflow), 1);
        check("ovf_count", int'(bus.count), 4);
        cyc(1'b1, 1'b0, 1'b1, 8'h60, 1'b1);
        check("fullpp_rIR", int'(bus.rIR), 8'h10);
        check("fullpp_count", int'(bus.count), 4);
        for (int i = 1; i < 4; i++) begin
            pop();
            check("ovf_drain_rIR", int'(bus.rIR), int'(fill[i]));
        end
        pop();
        check("ovf_last_rIR", int'(bus.rIR), 8'h60);

        // 4: flush with same-cycle push and pop
        push(8'h05);
        pop();
        push(8'h11);
        push(8'h22);
        check("preflush_rIR", int'(bus.rIR), 8'h05);
        cyc(1'b1, 1'b1, 1'b1, 8'h33, 1'b1);
        check("flush_count", int'(bus.count), 0);
        check("flush_empty", int'(bus.empty), 1);
        check("flush_rIR", int'(bus.rIR), 8'h05);
        check("flush_ovf", int'(bus.overflow), 0);
        pop();
        check("postflush_rIR", int'(bus.rIR), 8'h05);

        // 5: push+pop into an empty queue
        cyc(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        check("emptypp_rIR", int'(bus.rIR), BYP ? 8'h77 : 8'h05);
        check("emptypp_count", int'(bus.count), BYP ? 0 : 1);
        pop();
        check("emptypp_next_rIR", int'(bus.rIR), 8'h77);
        check("emptypp_next_count", int'(bus.count), 0);

        // 6: wrap with push/pop pairs, then reset mid-operation
        for (int i = 1; i <= 10; i++) cyc(1'b1, 1'b0, 1'b1, WIDTH'(i), 1'b1);
        check("wrap_rIR", int'(bus.rIR), BYP ? 8'h0A : 8'h09);
        check("wrap_count", int'(bus.count), BYP ? 0 : 1);
        push(8'hA5);
        push(8'h5A);
        cyc(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
        check_reset("midreset");
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
